// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - state encoding and elaboration-time timing helpers for the WS2812 strip driver
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } state_t;

    // A phase shorter than one clock still has to be visible on the line.
    function automatic longint ns_to_clk(input longint ns, input longint f_clk);
        longint cycles;
        cycles = (ns * f_clk) / 64'sd1_000_000_000;
        if (cycles < 1) cycles = 1;
        return cycles;
    endfunction

    function automatic longint us_to_clk(input longint us, input longint f_clk);
        longint cycles;
        cycles = (us * f_clk) / 64'sd1_000_000;
        if (cycles < 1) cycles = 1;
        return cycles;
    endfunction

    function automatic longint max_of(input longint a, input longint b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input longint max_count);
        return $clog2(max_count) + 1;
    endfunction

endpackage

// File: rtl/ws2812_phase_timer.sv
// rtl/ws2812_phase_timer.sv - loadable down-counter timing one HIGH, LOW or LATCH phase
module ws2812_phase_timer #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Load,
    input  logic [W-1:0] LoadValue,
    output logic         Expire
);

    logic [W-1:0] count;

    // Loading N-1 makes Expire land on the Nth cycle after the load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (Load) begin
            count <= LoadValue - W'(1);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign Expire = (count == '0);

endmodule

// File: rtl/ws2812_strip_driver.sv
// rtl/ws2812_strip_driver.sv - streams NUM_PIXELS words MSB-first onto a WS2812 line, then latches
module ws2812_strip_driver
    import ws2812_pkg::*;
#(
    parameter int F_CLK          = 12_000_000,
    parameter int BITS_PER_PIXEL = 24,
    parameter int NUM_PIXELS     = 8,
    parameter int T0H_NS         = 350,
    parameter int T0L_NS         = 800,
    parameter int T1H_NS         = 700,
    parameter int T1L_NS         = 600,
    parameter int TRESET_US      = 60
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [BITS_PER_PIXEL-1:0] PixelData,
    input  logic                      PixelValid,
    output logic                      PixelReady,
    output logic                      Ws2812Out,
    output logic                      Busy,
    output logic                      FrameDone,
    output logic                      Underrun
);

    localparam longint T0H_CLK  = ns_to_clk(longint'(T0H_NS), longint'(F_CLK));
    localparam longint T0L_CLK  = ns_to_clk(longint'(T0L_NS), longint'(F_CLK));
    localparam longint T1H_CLK  = ns_to_clk(longint'(T1H_NS), longint'(F_CLK));
    localparam longint T1L_CLK  = ns_to_clk(longint'(T1L_NS), longint'(F_CLK));
    localparam longint TRST_CLK = us_to_clk(longint'(TRESET_US), longint'(F_CLK));
    localparam longint MAX_CLK  = max_of(max_of(max_of(T0H_CLK, T1H_CLK),
                                                max_of(T0L_CLK, T1L_CLK)), TRST_CLK);
    localparam int     CW       = cnt_width(MAX_CLK);

    localparam logic [CW-1:0] T0H_V  = CW'(T0H_CLK);
    localparam logic [CW-1:0] T0L_V  = CW'(T0L_CLK);
    localparam logic [CW-1:0] T1H_V  = CW'(T1H_CLK);
    localparam logic [CW-1:0] T1L_V  = CW'(T1L_CLK);
    localparam logic [CW-1:0] TRST_V = CW'(TRST_CLK);

    localparam int BW = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_PIXEL - 1);
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_PIXELS - 1);

    state_t                    state;
    state_t                    next_state;
    logic [BITS_PER_PIXEL-1:0] shift_reg;
    logic [BW-1:0]             bit_idx;
    logic [PW-1:0]             pix_cnt;
    logic                      line_q;
    logic                      done_q;
    logic                      underrun_q;

    logic          expire;
    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          take_pixel;
    logic          shift_bit;
    logic          done_set;
    logic          underrun_set;
    logic          ready;
    logic          last_pixel;

    assign last_pixel = (pix_cnt == LAST_PIX);

    ws2812_phase_timer #(
        .W(CW)
    ) u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load     (tmr_load),
        .LoadValue(tmr_value),
        .Expire   (expire)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every phase transition reloads the timer in the same cycle, so bits and pixels abut.
    always_comb begin
        next_state   = state;
        tmr_load     = 1'b0;
        tmr_value    = '0;
        take_pixel   = 1'b0;
        shift_bit    = 1'b0;
        done_set     = 1'b0;
        underrun_set = 1'b0;
        ready        = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (PixelValid) begin
                    take_pixel = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_value  = PixelData[BITS_PER_PIXEL-1] ? T1H_V : T0H_V;
                    next_state = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (expire) begin
                    tmr_load   = 1'b1;
                    tmr_value  = shift_reg[BITS_PER_PIXEL-1] ? T1L_V : T0L_V;
                    next_state = ST_LOW;
                end
            end
            ST_LOW: begin
                if (expire) begin
                    tmr_load = 1'b1;
                    if (bit_idx != '0) begin
                        shift_bit  = 1'b1;
                        tmr_value  = shift_reg[BITS_PER_PIXEL-2] ? T1H_V : T0H_V;
                        next_state = ST_HIGH;
                    end else if (last_pixel) begin
                        tmr_value  = TRST_V;
                        next_state = ST_LATCH;
                    end else begin
                        ready = 1'b1;
                        if (PixelValid) begin
                            take_pixel = 1'b1;
                            tmr_value  = PixelData[BITS_PER_PIXEL-1] ? T1H_V : T0H_V;
                            next_state = ST_HIGH;
                        end else begin
                            underrun_set = 1'b1;
                            tmr_value    = TRST_V;
                            next_state   = ST_LATCH;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (expire) begin
                    done_set   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            shift_reg  <= '0;
            bit_idx    <= '0;
            pix_cnt    <= '0;
            line_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            line_q     <= (next_state == ST_HIGH);
            done_q     <= done_set;
            underrun_q <= underrun_set;
            if (take_pixel) begin
                shift_reg <= PixelData;
                bit_idx   <= LAST_BIT;
                pix_cnt   <= (state == ST_IDLE) ? '0 : pix_cnt + PW'(1);
            end else if (shift_bit) begin
                shift_reg <= {shift_reg[BITS_PER_PIXEL-2:0], 1'b0};
                bit_idx   <= bit_idx - BW'(1);
            end
        end
    end

    assign PixelReady = ready;
    assign Ws2812Out  = line_q;
    assign Busy       = (state != ST_IDLE);
    assign FrameDone  = done_q;
    assign Underrun   = underrun_q;

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// tb/tb_ws2812_strip_driver.sv - self-checking bench for ws2812_strip_driver
module tb_ws2812_strip_driver;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [23:0] PixelData = '0;
    logic        PixelValid = 1'b0;
    logic        PixelReady, Ws2812Out, Busy, FrameDone, Underrun;

    logic [31:0] data32 = '0;
    logic        valid32 = 1'b0;
    logic        ready32, line32, busy32, done32, und32;

    always #5 Clk = ~Clk;

    ws2812_strip_driver #(.NUM_PIXELS(3)) dut (
        .Clk(Clk), .Reset(Reset), .PixelData(PixelData), .PixelValid(PixelValid),
        .PixelReady(PixelReady), .Ws2812Out(Ws2812Out), .Busy(Busy),
        .FrameDone(FrameDone), .Underrun(Underrun)
    );

    ws2812_strip_driver #(.BITS_PER_PIXEL(32), .NUM_PIXELS(1)) dut32 (
        .Clk(Clk), .Reset(Reset), .PixelData(data32), .PixelValid(valid32),
        .PixelReady(ready32), .Ws2812Out(line32), .Busy(busy32),
        .FrameDone(done32), .Underrun(und32)
    );

    typedef struct {
        logic b;
        logic last;
    } exp_bit_t;

    typedef struct {
        int               n;
        logic [2:0][23:0] d;
        logic             junk;
        int               exp_und;
        int               exp_mid_ready;
    } frame_vec_t;

    exp_bit_t   exp_q[$];
    frame_vec_t vecs[4];

    int checks = 0;
    int failures = 0;
    int hcnt = 0, lcnt = 0, rises = 0;
    int done_cnt = 0, und_cnt = 0, und_lcnt = 0, mid_ready_cnt = 0, mon_err = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Scoreboard pop: one measured high/low pair per sent bit; latch time rides on the last bit.
    task automatic finalize_bit();
        exp_bit_t e;
        int eh, el;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL bit_unexpected high=%0d low=%0d required=no_bit", hcnt, lcnt);
        end else begin
            e  = exp_q.pop_front();
            eh = e.b ? 8 : 4;
            el = (e.b ? 7 : 9) + (e.last ? 720 : 0);
            if (hcnt != eh || lcnt != el) begin
                failures++;
                $display("FAIL bit_timing high=%0d low=%0d required high=%0d low=%0d",
                         hcnt, lcnt, eh, el);
            end
        end
        hcnt = 0;
        lcnt = 0;
    endtask

    always @(negedge Clk) begin
        if (Reset) begin
            hcnt = 0;
            lcnt = 0;
            exp_q.delete();
        end else begin
            if (FrameDone) begin
                if (hcnt > 0) finalize_bit();
                done_cnt++;
                if (Busy || Underrun || Ws2812Out) mon_err++;
            end else if (Ws2812Out) begin
                if (lcnt > 0) finalize_bit();
                if (hcnt == 0) rises++;
                hcnt++;
            end else if (hcnt > 0) begin
                lcnt++;
            end
            if (!FrameDone && hcnt > 0 && !Busy) mon_err++;
            if (Underrun) begin
                und_cnt++;
                und_lcnt = lcnt;
            end
            if (PixelReady && Busy) mid_ready_cnt++;
        end
    end

    task automatic push_pixel(input logic [23:0] d, input logic last_pixel);
        exp_bit_t e;
        for (int i = 23; i >= 0; i--) begin
            e.b    = d[i];
            e.last = last_pixel && (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_reset_and_check(input string name);
        @(negedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk); #1;
        check(name, {Ws2812Out, Busy, PixelReady, FrameDone, Underrun}, 5'b00100);
        Reset = 1'b0;
    endtask

    task automatic run_frame(input frame_vec_t v);
        int d0, u0, m0, k, budget;
        d0 = done_cnt; u0 = und_cnt; m0 = mid_ready_cnt;
        k = 0; budget = 0;
        while (k < v.n && budget < 4000) begin
            @(negedge Clk); #1;
            budget++;
            if (PixelReady) begin
                PixelValid = 1'b1;
                PixelData  = v.d[k];
                push_pixel(v.d[k], k == v.n - 1);
                @(posedge Clk); #1;
                k++;
                if (k < v.n && !v.junk) begin
                    PixelData = v.d[k];
                end else if (k < v.n) begin
                    PixelValid = 1'($urandom_range(0, 1));
                    PixelData  = 24'($urandom);
                end else begin
                    PixelValid = 1'b0;
                    PixelData  = 24'($urandom);
                end
            end else if (v.junk && k < v.n) begin
                PixelValid = 1'($urandom_range(0, 1));
                PixelData  = 24'($urandom);
            end
        end
        check("pixels_accepted", k, v.n);
        budget = 0;
        while (done_cnt == d0 && budget < 3000) begin
            @(negedge Clk); #1;
            budget++;
        end
        check("frame_done_count", done_cnt - d0, 1);
        check("underrun_count", und_cnt - u0, v.exp_und);
        check("mid_frame_ready", mid_ready_cnt - m0, v.exp_mid_ready);
        check("scoreboard_empty", exp_q.size(), 0);
        if (v.exp_und != 0)
            check("underrun_position", und_lcnt, (v.d[v.n-1][0] ? 7 : 9) + 1);
    endtask

    initial begin
        int d0, u0, budget, err, err32;

        vecs[0] = '{n: 3, d: {24'hAAAAAA, 24'h000000, 24'hFFFFFF}, junk: 1'b0, exp_und: 0, exp_mid_ready: 2};
        vecs[1] = '{n: 1, d: {24'h000000, 24'h000000, 24'h800000}, junk: 1'b1, exp_und: 1, exp_mid_ready: 1};
        vecs[2] = '{n: 2, d: {24'h000000, 24'hFEDCBA, 24'h123457}, junk: 1'b1, exp_und: 1, exp_mid_ready: 2};
        vecs[3] = '{n: 3, d: {24'h0F0F0F, 24'hC3C3C3, 24'h5A5A5A}, junk: 1'b1, exp_und: 0, exp_mid_ready: 2};

        pulse_reset_and_check("reset_outputs");

        for (int i = 0; i < 4; i++) run_frame(vecs[i]);

        // Abort on the third high cycle of bit 5 (a zero bit of 0xF0F0F0).
        @(negedge Clk); #1;
        rises = 0;
        PixelValid = 1'b1;
        PixelData  = 24'hF0F0F0;
        push_pixel(24'hF0F0F0, 1'b1);
        @(posedge Clk); #1;
        PixelValid = 1'b0;
        budget = 0;
        while (!(rises == 6 && hcnt == 3) && budget < 2000) begin
            @(negedge Clk); #1;
            budget++;
        end
        check("abort_point_reached", (rises == 6 && hcnt == 3), 1);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk); #1;
        check("abort_outputs", {Ws2812Out, Busy, PixelReady, FrameDone, Underrun}, 5'b00100);
        Reset = 1'b0;
        d0 = done_cnt; u0 = und_cnt; rises = 0;
        repeat (800) @(negedge Clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_no_underrun", und_cnt - u0, 0);
        check("abort_line_quiet", rises, 0);
        run_frame(vecs[0]);

        // Idle with PixelValid low.
        d0 = done_cnt; u0 = und_cnt; rises = 0; err = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge Clk); #1;
            if (Busy || Ws2812Out || !PixelReady) err++;
        end
        check("idle_quiet_cycles", err, 0);
        check("idle_no_pulses", (done_cnt - d0) + (und_cnt - u0), 0);
        check("idle_no_rises", rises, 0);

        // 32-bit single-pixel instance against a hand-written waveform.
        err32 = 0;
        @(negedge Clk); #1;
        if (!ready32 || busy32) err32++;
        valid32 = 1'b1;
        data32  = 32'hFFFFFFFF;
        @(posedge Clk); #1;
        valid32 = 1'b0;
        for (int b = 0; b < 32; b++) begin
            for (int c = 0; c < 15; c++) begin
                @(negedge Clk); #1;
                if (line32 != (c < 8) || !busy32 || ready32 || done32 || und32) err32++;
            end
        end
        for (int c = 0; c < 720; c++) begin
            @(negedge Clk); #1;
            if (line32 || !busy32 || ready32 || done32 || und32) err32++;
        end
        check("w32_waveform_errors", err32, 0);
        @(negedge Clk); #1;
        check("w32_frame_done", {line32, busy32, ready32, done32, und32}, 5'b00110);
        @(negedge Clk); #1;
        check("w32_done_one_cycle", done32, 0);

        check("monitor_protocol_errors", mon_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ws2812_strip_driver.md
Name: ws2812_strip_driver

Overview:
- Parametrised WS2812/SK6812 strip driver; successor to the single-word bit controller.
- Accepts a frame of NUM_PIXELS pixel words over a valid/ready stream and serialises each word MSB-first with exact per-bit high/low timing.
- Inserts the reset/latch low period after each frame and reports completion or underrun.
- Sits between the pixel framebuffer reader and the output pin.

Parameters:
- F_CLK, 12_000_000: clock frequency in Hz.
- BITS_PER_PIXEL, 24: bits per pixel; 24 for GRB, 32 for RGBW.
- NUM_PIXELS, 8: pixels per frame, minimum 1.
- T0H_NS, 350: zero-bit high time in ns.
- T0L_NS, 800: zero-bit low time in ns.
- T1H_NS, 700: one-bit high time in ns.
- T1L_NS, 600: one-bit low time in ns.
- TRESET_US, 60: latch low time in us.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous reset, active-high.
- PixelData  in  BITS_PER_PIXEL  pixel word; bit BITS_PER_PIXEL-1 is sent first.
- PixelValid  in  1  PixelData is valid.
- PixelReady  out  1  driver accepts PixelData this cycle.
- Ws2812Out  out  1  serial line to the LED strip.
- Busy  out  1  frame in progress (state != IDLE).
- FrameDone  out  1  one-cycle pulse when the latch period has ended.
- Underrun  out  1  one-cycle pulse when a pixel was needed but PixelValid was low.

Behaviour:
- Single clock Clk. Reset is synchronous and active-high.
- Reset values, and values on the cycle after Reset: Ws2812Out=0, FrameDone=0, Underrun=0, Busy=0, PixelReady=1. All counters are cleared and the shift register is zeroed.
- Reset asserted mid-frame aborts the frame immediately: no FrameDone, no Underrun, and the in-flight pixel is dropped.
- Cycle counts are fixed at elaboration:
  - TxX_CLK = floor(TxX_NS*F_CLK/1e9), clamped to a minimum of 1. At 12 MHz: T0H=4, T0L=9, T1H=8, T1L=7.
  - TRST_CLK = TRESET_US*F_CLK/1e6 (720 at the defaults).
  - Arithmetic is 64-bit at elaboration time. The phase counter is clog2(max count)+1 bits wide.
- State machine IDLE -> HIGH -> LOW -> (HIGH | LATCH) -> IDLE.
- IDLE:
  - Ws2812Out=0, PixelReady=1.
  - On PixelValid&&PixelReady: load the shift register, set the bit index to BITS_PER_PIXEL-1 and the pixel count to 0, go to HIGH.
- HIGH:
  - Ws2812Out=1 for exactly T1H_CLK or T0H_CLK cycles, selected by the current MSB.
  - The first high cycle is the cycle after the handshake (output is registered).
- LOW:
  - Ws2812Out=0 for exactly T1L_CLK or T0L_CLK cycles.
  - On the final LOW cycle:
    - If bits remain: shift left and go to HIGH.
    - If the last bit of the last pixel: go to LATCH.
    - If the last bit of a non-last pixel: PixelReady=1 in this cycle. If PixelValid, load the next word, increment the pixel count and go to HIGH with no gap. Otherwise pulse Underrun next cycle and go to LATCH (truncated frame).
- PixelReady is decoded from state and counters only. It never depends on PixelValid combinationally.
- LATCH:
  - Ws2812Out=0 for TRST_CLK cycles.
  - On the cycle after the last one: FrameDone=1, state returns to IDLE, PixelReady=1.
  - A handshake in that same cycle starts a new frame.
- No dead cycles between bits or pixels. Bit period = TxH_CLK+TxL_CLK exactly.
- PixelData is sampled only on a handshake. Changes at any other time are ignored.
- Underrun and FrameDone never assert in the same cycle. After an Underrun, FrameDone follows once LATCH completes.

Decomposition:
- ws2812_pkg holds:
  - the state enum (IDLE, HIGH, LOW, LATCH);
  - the ns/us to cycle-count functions with clamp-to-1;
  - a shared counter-width function.
- Sub-module ws2812_phase_timer: a down-counter with Load, LoadValue and Expire. Expire is high on the final cycle of the loaded count. It is reused for the HIGH, LOW and LATCH phases.

Test Plan:
- NUM_PIXELS=1, PixelData=0x800000 -> high 8 / low 7, then 23 repetitions of high 4 / low 9. Then 720 low cycles, then FrameDone one cycle later. Busy spans the whole sequence.
- NUM_PIXELS=3, PixelValid held at 1, data 0xFFFFFF/0x000000/0xAAAAAA:
  - PixelReady pulses exactly 3 times.
  - Pixel 0 bits are 15-cycle periods and pixel 1 bits are 13-cycle periods.
  - Pixel 2 bits alternate 15/13 cycles.
  - No gap cycles between pixels; one FrameDone at the end.
- NUM_PIXELS=4, only 2 pixels supplied -> Underrun pulse after the last bit of pixel 1. Then 720 low cycles, then FrameDone. Pixels 2-3 are never sent.
- Reset asserted on the 3rd high cycle of bit 5 -> next cycle Ws2812Out=0, Busy=0, PixelReady=1. No FrameDone. The following frame has exact timing.
- BITS_PER_PIXEL=32, PixelData=0xFFFFFFFF -> 32 bits of high 8 / low 7, then latch.
- PixelValid held at 0 for 1000 cycles from IDLE -> Ws2812Out stays 0, Busy stays 0, no pulses on FrameDone or Underrun.
